// File: rtl/direction_accumulator.sv
// direction_accumulator: pipelined per-bin phase-difference projection, accumulated into one saturated {x,y} vector per frame
module direction_accumulator #(
   parameter int NUM_MICS = 3,
   parameter int MIC_X [NUM_MICS] = '{0, -1, 1},
   parameter int MIC_Y [NUM_MICS] = '{1, -1, -1},
   parameter int ACC_WIDTH = 32,
   parameter int OUT_SHIFT = 2
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic [31:0]              central_mic_in,
   input  logic [32*NUM_MICS-1:0]   peripheral_mics_in,
   input  logic                     valid_in,
   input  logic                     last_in,
   input  logic                     weight_en_in,
   output logic [31:0]              vector_out,
   output logic                     vector_valid_out,
   output logic                     sat_out,
   output logic [15:0]              bin_count_out
);
   localparam logic signed [16:0] LIM = 17'sh06488;
   localparam logic signed [16:0] STEP = 17'sh0C910;
   localparam logic signed [ACC_WIDTH-1:0] HI = ACC_WIDTH'(32767);
   localparam logic signed [ACC_WIDTH-1:0] LO = ACC_WIDTH'(-32768);

   function automatic logic [16:0] sat16(input logic signed [ACC_WIDTH-1:0] v);
      return v > HI ? {1'b1, 16'h7FFF} : v < LO ? {1'b1, 16'h8000} : {1'b0, v[15:0]};
   endfunction

   logic frame_open, wmode;
   logic s1_valid, s1_last, s1_wt;
   logic [15:0] s1_mag;
   logic signed [16:0] raw [NUM_MICS];
   logic signed [16:0] d_nxt [NUM_MICS];
   logic signed [16:0] s1_d [NUM_MICS];
   logic signed [33:0] prod [NUM_MICS];
   logic signed [16:0] w_nxt [NUM_MICS];
   logic s2_valid, s2_last;
   logic signed [16:0] s2_w [NUM_MICS];
   logic s3_valid, s3_last;
   logic signed [ACC_WIDTH-1:0] sx_nxt, sy_nxt, s3_sx, s3_sy;
   logic signed [ACC_WIDTH-1:0] acc_x, acc_y, tot_x, tot_y;
   logic [16:0] qx, qy;
   logic [15:0] bin_cnt;
   logic unused_mags;

   always_comb begin
      unused_mags = 1'b0;
      for (int i = 0; i < NUM_MICS; i++) begin
         unused_mags = unused_mags ^ (^peripheral_mics_in[32*i +: 16]);
         raw[i] = 17'($signed(peripheral_mics_in[32*i+16 +: 16])) - 17'($signed(central_mic_in[31:16]));
         d_nxt[i] = raw[i] > LIM ? raw[i] - STEP : raw[i] < -LIM ? raw[i] + STEP : raw[i];
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_MICS; i++) begin
         prod[i] = (34'(s1_d[i]) * 34'($signed({1'b0, s1_mag}))) >>> 13;
         w_nxt[i] = !s1_wt ? s1_d[i] :
                    prod[i] > 34'sd65535 ? 17'sh0FFFF :
                    prod[i] < -34'sd65536 ? 17'sh10000 : prod[i][16:0];
      end
   end

   // location entries are -1/0/1, so each term is a subtract, skip or add
   always_comb begin
      sx_nxt = '0;
      sy_nxt = '0;
      for (int i = 0; i < NUM_MICS; i++) begin
         sx_nxt = MIC_X[i] > 0 ? sx_nxt + ACC_WIDTH'(s2_w[i]) : MIC_X[i] < 0 ? sx_nxt - ACC_WIDTH'(s2_w[i]) : sx_nxt;
         sy_nxt = MIC_Y[i] > 0 ? sy_nxt + ACC_WIDTH'(s2_w[i]) : MIC_Y[i] < 0 ? sy_nxt - ACC_WIDTH'(s2_w[i]) : sy_nxt;
      end
   end

   always_comb begin
      tot_x = acc_x + s3_sx;
      tot_y = acc_y + s3_sy;
      qx = sat16(tot_x >>> OUT_SHIFT);
      qy = sat16(tot_y >>> OUT_SHIFT);
   end

   always_ff @(posedge clk_in) begin
      s1_d <= d_nxt;
      s1_mag <= central_mic_in[15:0];
      s1_last <= last_in;
      s1_wt <= frame_open ? wmode : weight_en_in;
      s2_w <= w_nxt;
      s2_last <= s1_last;
      s3_sx <= sx_nxt;
      s3_sy <= sy_nxt;
      s3_last <= s2_last;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         frame_open <= 1'b0;
         wmode <= 1'b0;
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s3_valid <= 1'b0;
         acc_x <= '0;
         acc_y <= '0;
         bin_cnt <= '0;
         vector_out <= '0;
         vector_valid_out <= 1'b0;
         sat_out <= 1'b0;
         bin_count_out <= '0;
      end else begin
         s1_valid <= valid_in;
         s2_valid <= s1_valid;
         s3_valid <= s2_valid;
         vector_valid_out <= s3_valid && s3_last;
         if (valid_in) begin
            frame_open <= !last_in;
            if (!frame_open) wmode <= weight_en_in;
         end
         if (s3_valid && s3_last) begin
            vector_out <= {qx[15:0], qy[15:0]};
            sat_out <= qx[16] | qy[16];
            bin_count_out <= &bin_cnt ? bin_cnt : bin_cnt + 16'd1;
            acc_x <= '0;
            acc_y <= '0;
            bin_cnt <= '0;
         end else if (s3_valid) begin
            acc_x <= tot_x;
            acc_y <= tot_y;
            bin_cnt <= &bin_cnt ? bin_cnt : bin_cnt + 16'd1;
         end
      end
   end
endmodule

// File: tb/tb_direction_accumulator.sv
// tb_direction_accumulator: directed-vector bench for direction_accumulator with hand-computed frame results
module tb_direction_accumulator;
   logic clk_in = 1'b0;
   logic rst_in;
   logic [31:0] central_mic_in;
   logic [95:0] peripheral_mics_in;
   logic valid_in, last_in, weight_en_in;
   logic [31:0] vector_out;
   logic vector_valid_out, sat_out;
   logic [15:0] bin_count_out;
   int checks = 0;
   int failures = 0;
   logic [31:0] vq[$];
   logic sq[$];
   logic [15:0] cq[$];

   direction_accumulator dut (
      .clk_in(clk_in), .rst_in(rst_in), .central_mic_in(central_mic_in),
      .peripheral_mics_in(peripheral_mics_in), .valid_in(valid_in), .last_in(last_in),
      .weight_en_in(weight_en_in), .vector_out(vector_out), .vector_valid_out(vector_valid_out),
      .sat_out(sat_out), .bin_count_out(bin_count_out)
   );

   always #5 clk_in = ~clk_in;

   always @(negedge clk_in) if (vector_valid_out) begin
      vq.push_back(vector_out);
      sq.push_back(sat_out);
      cq.push_back(bin_count_out);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic bin(input logic [15:0] cph, cmag, p0, p1, p2, input logic last, wen);
      valid_in = 1'b1;
      last_in = last;
      weight_en_in = wen;
      central_mic_in = {cph, cmag};
      peripheral_mics_in = {p2, 16'h0055, p1, 16'h0055, p0, 16'h0055};
      @(posedge clk_in);
      #1;
      valid_in = 1'b0;
      last_in = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic expect_frame(input string tag, input logic [31:0] v, input logic s, input logic [15:0] c);
      check({tag, "_present"}, 64'(vq.size() > 0), 64'd1);
      if (vq.size() > 0) begin
         check({tag, "_vec"}, 64'(vq.pop_front()), 64'(v));
         check({tag, "_sat"}, 64'(sq.pop_front()), 64'(s));
         check({tag, "_cnt"}, 64'(cq.pop_front()), 64'(c));
      end
   endtask

   initial begin
      int lat;
      rst_in = 1'b1;
      valid_in = 1'b0;
      last_in = 1'b0;
      weight_en_in = 1'b0;
      central_mic_in = '0;
      peripheral_mics_in = '0;
      idle(3);
      check("rst_vec", 64'(vector_out), 64'd0);
      check("rst_valid", 64'(vector_valid_out), 64'd0);
      check("rst_sat", 64'(sat_out), 64'd0);
      check("rst_cnt", 64'(bin_count_out), 64'd0);
      rst_in = 1'b0;
      idle(1);

      bin(16'h0000, 16'h0000, 16'h2000, 16'h0000, 16'h0000, 1'b1, 1'b0);
      lat = 10;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk_in);
         if (vector_valid_out) begin
            lat = k;
            break;
         end
      end
      check("latency", 64'(lat), 64'd3);
      idle(4);
      expect_frame("single", 32'h0000_0800, 1'b0, 16'd1);
      check("hold_vec", 64'(vector_out), 64'h0000_0800);

      bin(16'h6000, 16'h0000, 16'hA000, 16'h6000, 16'h6000, 1'b1, 1'b0);
      bin(16'h0000, 16'h0000, 16'h6488, 16'h0000, 16'h0000, 1'b1, 1'b0);
      bin(16'h6488, 16'h0000, 16'h0000, 16'h6488, 16'h6488, 1'b1, 1'b0);
      idle(6);
      expect_frame("wrap", 32'h0000_0244, 1'b0, 16'd1);
      expect_frame("edge_pos", 32'h0000_1922, 1'b0, 16'd1);
      expect_frame("edge_neg", 32'h0000_E6DE, 1'b0, 16'd1);

      for (int k = 0; k < 4; k++) begin
         logic [15:0] c;
         c = 16'h0100 * 16'(k);
         bin(c, 16'h0000, c, c, c + 16'h1000, k == 3, 1'b0);
      end
      bin(16'h7000, 16'h0000, 16'h7000, 16'h7000, 16'h7000, 1'b1, 1'b0);
      idle(6);
      expect_frame("four_bin", 32'h1000_F000, 1'b0, 16'd4);
      expect_frame("after_clear", 32'h0000_0000, 1'b0, 16'd1);

      for (int k = 0; k < 8; k++) bin(16'h0000, 16'h0000, 16'h6000, 16'h0000, 16'h0000, k == 7, 1'b0);
      for (int k = 0; k < 8; k++) bin(16'h0000, 16'h0000, 16'h0000, 16'h6000, 16'h0000, k == 7, 1'b0);
      idle(6);
      expect_frame("sat_pos", 32'h0000_7FFF, 1'b1, 16'd8);
      expect_frame("sat_neg", 32'h8000_8000, 1'b1, 16'd8);

      bin(16'h0000, 16'h1000, 16'h2000, 16'h0000, 16'h0000, 1'b1, 1'b1);
      bin(16'h0000, 16'h1000, 16'h2000, 16'h0000, 16'h0000, 1'b0, 1'b0);
      bin(16'h0000, 16'h1000, 16'h2000, 16'h0000, 16'h0000, 1'b1, 1'b1);
      bin(16'h0000, 16'h1000, 16'h2000, 16'h0000, 16'h0000, 1'b0, 1'b1);
      bin(16'h0000, 16'h1000, 16'h2000, 16'h0000, 16'h0000, 1'b1, 1'b0);
      idle(6);
      expect_frame("weight", 32'h0000_0400, 1'b0, 16'd1);
      expect_frame("wt_off_toggle", 32'h0000_1000, 1'b0, 16'd2);
      expect_frame("wt_on_toggle", 32'h0000_0800, 1'b0, 16'd2);

      bin(16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h0000, 1'b0, 1'b0);
      bin(16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h0000, 1'b0, 1'b0);
      rst_in = 1'b1;
      idle(1);
      rst_in = 1'b0;
      idle(6);
      check("rst_mid_no_frame", 64'(vq.size()), 64'd0);
      check("rst_mid_vec", 64'(vector_out), 64'd0);
      check("rst_mid_cnt", 64'(bin_count_out), 64'd0);
      bin(16'h0000, 16'h0000, 16'h1000, 16'h0000, 16'h0000, 1'b1, 1'b0);
      idle(6);
      expect_frame("post_rst", 32'h0000_0400, 1'b0, 16'd1);
      check("no_extra_frames", 64'(vq.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
